seven_seg_capture: RTL and testbench
====================================

// Module: seven_seg_capture
// PURPOSE
//   Receive side of the multiplexed 4-digit seven-segment bus (digs/segs) driven by the display
//   driver. Watches the scanned digit strobes, filters ghosting and transitions, and decodes each
//   digit's segment pattern back to BCD plus its dot. Reassembles full 4-digit frames.
//   Used for on-board loopback self-test of the display path and by the controller to read back
//   what the display shows.
// PARAMETERS
//   STABLE_CYCLES  4          consecutive identical (digs,segs) cycles required before a digit is captured (>=1)
//   BLANK_TIMEOUT  100000     cycles with no digit strobe active before blanked asserts (>=2)
//   DIG_ACTIVE_LOW 1          1: digs bit low = digit selected; 0: high = selected
//   SEG_ACTIVE_LOW 0          1: segs bit low = segment lit; 0: high = lit
// PORTS
//   clk          in   1   system clock
//   reset        in   1   synchronous, active-high reset
//   digs         in   4   digit strobes from display bus; digs[i] selects digit i
//   segs         in   8   segments {dp,g,f,e,d,c,b,a} = segs[7:0]
//   bcd          out  16  last complete frame; digit i in bcd[4i+3:4i]
//   dots         out  4   last complete frame dot per digit
//   frame_valid  out  1   one-cycle pulse: bcd/dots/seg_err just updated
//   blanked      out  1   level: no strobe seen for BLANK_TIMEOUT cycles
//   seg_err      out  1   last complete frame contained an undecodable pattern
//   mux_err      out  1   one-cycle pulse: more than one digit strobe active this cycle
// BEHAVIOUR
//   - Reset: bcd=0, dots=0, frame_valid=0, blanked=0, seg_err=0, mux_err=0; capture mask, shadow
//     registers, stability and idle counters cleared. Reset mid-frame discards the partial frame.
//   - Inputs normalized by polarity params, then registered once (1-cycle input stage); all
//     timing below counts from the registered sample.
//   - Sample classes: NONE (no strobe), ONE (exactly one strobe, index i), MULTI (>1 strobe).
//   - MULTI: mux_err high the next cycle (one pulse per MULTI sample); stability counter cleared.
//   - ONE: if (digs,segs) equal previous sample, stable count increments (saturating), else count=1.
//     When count reaches STABLE_CYCLES, capture digit i exactly once: shadow[i] <= decode(segs[6:0]),
//     shadow_dp[i] <= segs[7], mask[i] <= 1. No re-capture until the sample changes.
//     A later capture of the same digit in the same frame overwrites (latest wins).
//   - Decode (a..g = bit0..6): 3F->0 06->1 5B->2 4F->3 66->4 6D->5 7D->6 07->7 7F->8 6F->9;
//     any other pattern -> nibble 4'hF and frame error flag set for the frame.
//   - Frame completion: on the edge where the capture makes mask==4'b1111: bcd, dots and seg_err
//     load from shadow (including this capture); mask and frame error clear; frame_valid high the
//     following cycle for exactly one cycle. Latency fourth-digit stable -> frame_valid = 1 cycle.
//   - Digits may arrive in any order; frame is complete when all four captured, not in scan order.
//   - NONE: stability counter cleared; idle counter increments (saturating at BLANK_TIMEOUT).
//     When it reaches BLANK_TIMEOUT: blanked=1, mask and frame error cleared, outputs bcd/dots held.
//     Any ONE sample clears idle counter; blanked clears on the next digit capture.
//   - ONE or MULTI sample clears the idle counter.
//   - Counters sized $clog2(param+1); no wrap-around anywhere (all saturate).
//   - STABLE_CYCLES=1: capture on the first cycle a new ONE sample appears.
// TESTING
//   1. Drive 1,2,3,4 on digits 0..3, each 8 cycles, dp on digit 2 -> frame_valid one pulse, bcd=16'h4321, dots=4'b0100, seg_err=0.
//   2. Digit 1 held only STABLE_CYCLES-1 cycles then changes -> no capture; frame_valid absent until digit 1 held >=4 cycles.
//   3. Digit 3 pattern 8'h49 (invalid) within frame -> bcd[15:12]=4'hF, seg_err=1; next clean frame -> seg_err=0.
//   4. digs selects digits 0 and 1 together for 3 cycles -> mux_err pulses 3 times, no capture, bcd unchanged.
//   5. Strobes idle BLANK_TIMEOUT cycles after 2 digits captured -> blanked=1, partial frame dropped; next full frame -> blanked=0, frame_valid.
//   6. reset asserted after 3 digits captured -> all outputs 0 next cycle; 4th digit alone afterwards -> no frame_valid.

Source files
------------

// File: rtl/seven_seg_capture.sv
// Receive side of a multiplexed 4-digit seven-segment bus: filters scanned strobes,
// decodes each stable digit back to BCD + dot and reassembles complete 4-digit frames.
module seven_seg_capture #(
    parameter int STABLE_CYCLES  = 4,
    parameter int BLANK_TIMEOUT  = 100000,
    parameter bit DIG_ACTIVE_LOW = 1'b1,
    parameter bit SEG_ACTIVE_LOW = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  digs,
    input  logic [7:0]  segs,
    output logic [15:0] bcd,
    output logic [3:0]  dots,
    output logic        frame_valid,
    output logic        blanked,
    output logic        seg_err,
    output logic        mux_err
);
    localparam int SW = $clog2(STABLE_CYCLES + 1);
    localparam int IW = $clog2(BLANK_TIMEOUT + 1);
    localparam logic [SW-1:0] S_MAX = SW'(STABLE_CYCLES);
    localparam logic [IW-1:0] I_MAX = IW'(BLANK_TIMEOUT);

    // returns {invalid, nibble}
    function automatic logic [4:0] decode(input logic [6:0] s);
        case (s)
            7'h3F:   decode = 5'h00;
            7'h06:   decode = 5'h01;
            7'h5B:   decode = 5'h02;
            7'h4F:   decode = 5'h03;
            7'h66:   decode = 5'h04;
            7'h6D:   decode = 5'h05;
            7'h7D:   decode = 5'h06;
            7'h07:   decode = 5'h07;
            7'h7F:   decode = 5'h08;
            7'h6F:   decode = 5'h09;
            default: decode = 5'h1F;
        endcase
    endfunction

    logic [3:0]    digs_p0, digs_p1;
    logic [7:0]    segs_p0, segs_p1;
    logic [SW-1:0] stab, stab_next;
    logic [IW-1:0] idle, idle_next;
    logic [3:0]    mask, mask_cap, shadow_dp, dots_cap;
    logic [15:0]   shadow, shadow_cap;
    logic          ferr;
    logic          is_none, is_one, is_multi, same, capture, frame_done, idle_hit;
    logic [1:0]    idx;
    logic [4:0]    dec;

    // stage p0: polarity-normalised input sample; p1: previous sample for stability compare
    always_ff @(posedge clk) begin
        digs_p0 <= DIG_ACTIVE_LOW ? ~digs : digs;
        segs_p0 <= SEG_ACTIVE_LOW ? ~segs : segs;
        digs_p1 <= digs_p0;
        segs_p1 <= segs_p0;
    end

    always_comb begin
        is_none   = (digs_p0 == 4'b0000);
        is_one    = $onehot(digs_p0);
        is_multi  = !is_none && !is_one;
        same      = (digs_p0 == digs_p1) && (segs_p0 == segs_p1);
        idx       = 2'd0;
        for (int k = 0; k < 4; k++)
            if (digs_p0[k]) idx = 2'(k);
        dec       = decode(segs_p0[6:0]);
        stab_next = '0;
        capture   = 1'b0;
        if (is_one) begin
            if (same) stab_next = (stab == S_MAX) ? stab : stab + SW'(1);
            else      stab_next = SW'(1);
            // a sample that has already been captured and stays put must not re-capture
            capture = (stab_next == S_MAX) && !(same && stab == S_MAX);
        end
        idle_next = '0;
        if (is_none) idle_next = (idle == I_MAX) ? idle : idle + IW'(1);
        idle_hit  = is_none && (idle_next == I_MAX);
        mask_cap  = mask | (4'b0001 << idx);
        frame_done = capture && (mask_cap == 4'b1111);
        shadow_cap = shadow;
        shadow_cap[{idx, 2'b00} +: 4] = dec[3:0];
        dots_cap   = shadow_dp;
        dots_cap[idx] = segs_p0[7];
    end

    // stage p1: capture, frame assembly and status
    always_ff @(posedge clk) begin
        if (reset) begin
            stab        <= '0;
            idle        <= '0;
            mask        <= '0;
            ferr        <= 1'b0;
            shadow      <= '0;
            shadow_dp   <= '0;
            bcd         <= '0;
            dots        <= '0;
            frame_valid <= 1'b0;
            blanked     <= 1'b0;
            seg_err     <= 1'b0;
            mux_err     <= 1'b0;
        end else begin
            stab        <= stab_next;
            idle        <= idle_next;
            mux_err     <= is_multi;
            frame_valid <= frame_done;
            if (capture) begin
                shadow    <= shadow_cap;
                shadow_dp <= dots_cap;
                blanked   <= 1'b0;
                if (frame_done) begin
                    bcd     <= shadow_cap;
                    dots    <= dots_cap;
                    seg_err <= ferr | dec[4];
                    mask    <= '0;
                    ferr    <= 1'b0;
                end else begin
                    mask    <= mask_cap;
                    ferr    <= ferr | dec[4];
                end
            end else if (idle_hit) begin
                blanked <= 1'b1;
                mask    <= '0;
                ferr    <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_seven_seg_capture.sv
// Scoreboard bench for seven_seg_capture: directed bus scans, expected frames queued ahead.
module tb_seven_seg_capture;
    localparam int SC = 4;
    localparam int BT = 40;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  digs;
    logic [7:0]  segs;
    logic [15:0] bcd;
    logic [3:0]  dots;
    logic        frame_valid, blanked, seg_err, mux_err;

    int total = 0;
    int bad = 0;
    int frame_cnt = 0;
    int mux_cnt = 0;
    logic [20:0] exp_q[$];

    seven_seg_capture #(
        .STABLE_CYCLES(SC), .BLANK_TIMEOUT(BT),
        .DIG_ACTIVE_LOW(1'b1), .SEG_ACTIVE_LOW(1'b0)
    ) dut (
        .clk(clk), .reset(reset), .digs(digs), .segs(segs),
        .bcd(bcd), .dots(dots), .frame_valid(frame_valid),
        .blanked(blanked), .seg_err(seg_err), .mux_err(mux_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // monitor: pops the scoreboard whenever the DUT presents a frame
    always @(negedge clk) begin
        if (!reset && mux_err) mux_cnt++;
        if (!reset && frame_valid) begin
            logic [20:0] e;
            frame_cnt++;
            if (exp_q.size() == 0) begin
                check("unexpected_frame", {11'd0, bcd, dots, seg_err}, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check("frame_bcd", {16'd0, bcd}, {16'd0, e[20:5]});
                check("frame_dots", {28'd0, dots}, {28'd0, e[4:1]});
                check("frame_seg_err", {31'd0, seg_err}, {31'd0, e[0]});
            end
        end
    end

    task automatic drive(input int d, input logic [7:0] s, input int n);
        digs = ~(4'b0001 << d);
        segs = s;
        repeat (n) @(negedge clk);
    endtask

    task automatic idle(input int n);
        digs = 4'hF;
        segs = 8'h00;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int fc, mc;
        reset = 1'b1;
        digs  = 4'hF;
        segs  = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_bcd", {16'd0, bcd}, 32'd0);
        check("rst_flags", {26'd0, dots, frame_valid, blanked}, 32'd0);
        check("rst_errs", {30'd0, seg_err, mux_err}, 32'd0);
        reset = 1'b0;
        idle(3);

        // 1: basic frame, dp on digit 2
        exp_q.push_back({16'h4321, 4'b0100, 1'b0});
        drive(0, 8'h06, 8); drive(1, 8'h5B, 8); drive(2, 8'hCF, 8); drive(3, 8'h66, 8);
        idle(5);
        check("t1_frames", frame_cnt, 1);

        // 2: digit 1 too short, then held long enough
        drive(0, 8'h06, 8); drive(1, 8'h5B, SC - 1); drive(2, 8'h4F, 8); drive(3, 8'h66, 8);
        idle(5);
        check("t2_no_frame", frame_cnt, 1);
        exp_q.push_back({16'h4321, 4'b0000, 1'b0});
        drive(1, 8'h5B, SC);
        idle(5);
        check("t2_frame", frame_cnt, 2);

        // 3: invalid pattern on digit 3, then clean frame
        exp_q.push_back({16'hF321, 4'b0000, 1'b1});
        drive(0, 8'h06, 6); drive(1, 8'h5B, 6); drive(2, 8'h4F, 6); drive(3, 8'h49, 6);
        idle(5);
        exp_q.push_back({16'h4321, 4'b0000, 1'b0});
        drive(0, 8'h06, 6); drive(1, 8'h5B, 6); drive(2, 8'h4F, 6); drive(3, 8'h66, 6);
        idle(5);
        check("t3_frames", frame_cnt, 4);

        // 4: two strobes at once
        mc = mux_cnt;
        fc = frame_cnt;
        digs = ~4'b0011;
        segs = 8'h06;
        repeat (3) @(negedge clk);
        idle(5);
        check("t4_mux_pulses", mux_cnt - mc, 3);
        check("t4_bcd_held", {16'd0, bcd}, 32'h4321);
        check("t4_no_frame", frame_cnt, fc);

        // 5: blank timeout drops partial frame
        drive(0, 8'h06, 6); drive(1, 8'h5B, 6);
        idle(5);
        check("t5_not_blank_yet", {31'd0, blanked}, 32'd0);
        idle(BT);
        check("t5_blanked", {31'd0, blanked}, 32'd1);
        check("t5_bcd_held", {16'd0, bcd}, 32'h4321);
        fc = frame_cnt;
        drive(2, 8'h07, 6);
        @(negedge clk);
        check("t5_unblank", {31'd0, blanked}, 32'd0);
        drive(3, 8'h7F, 6);
        idle(5);
        check("t5_partial_dropped", frame_cnt, fc);
        exp_q.push_back({16'h8765, 4'b0000, 1'b0});
        drive(0, 8'h6D, 6); drive(1, 8'h7D, 6);
        idle(5);
        check("t5_frame", frame_cnt, fc + 1);

        // 6: reset mid-frame
        drive(0, 8'h06, 6); drive(1, 8'h5B, 6); drive(2, 8'h4F, 6);
        digs = 4'hF;
        reset = 1'b1;
        @(negedge clk);
        check("t6_bcd", {16'd0, bcd}, 32'd0);
        check("t6_flags", {26'd0, dots, frame_valid, blanked}, 32'd0);
        check("t6_errs", {30'd0, seg_err, mux_err}, 32'd0);
        reset = 1'b0;
        fc = frame_cnt;
        idle(2);
        drive(3, 8'h66, 8);
        idle(5);
        check("t6_no_frame", frame_cnt, fc);

        check("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
